// File: rtl/ps2_key_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_pkg
// Shared definitions for the PS/2 set-2 key decoder:
//   - prefix byte constants (break F0, extended E0)
//   - the list of bytes that are dropped outright (BAT/ack/resend/error codes)
//   - the decoder state enum
//   - the tracked movement-key table, index -> {ext, code}
// ---------------------------------------------------------------------------
package ps2_key_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Keyboard housekeeping bytes that never form part of a key event.
  localparam int NUM_IGNORE = 6;
  localparam logic [NUM_IGNORE-1:0][7:0] IGNORE_SET = {
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF
  };

  localparam int NUM_KEYS = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_entry_t;

  // Tracked-key table. The index is the bit position in the held bitmap,
  // and lower indices win when falling back to a still-held key.
  function automatic key_entry_t keyEntry(input logic [3:0] idx);
    key_entry_t e;
    case (idx)
      4'd0:    e = '{ext: 1'b0, code: 8'h1D};
      4'd1:    e = '{ext: 1'b0, code: 8'h1C};
      4'd2:    e = '{ext: 1'b0, code: 8'h1B};
      4'd3:    e = '{ext: 1'b0, code: 8'h23};
      4'd4:    e = '{ext: 1'b0, code: 8'h15};
      4'd5:    e = '{ext: 1'b0, code: 8'h24};
      4'd6:    e = '{ext: 1'b0, code: 8'h2D};
      4'd7:    e = '{ext: 1'b0, code: 8'h2B};
      4'd8:    e = '{ext: 1'b1, code: 8'h75};
      4'd9:    e = '{ext: 1'b1, code: 8'h72};
      4'd10:   e = '{ext: 1'b1, code: 8'h6B};
      4'd11:   e = '{ext: 1'b1, code: 8'h74};
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic isIgnoreByte(input logic [7:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_IGNORE; i++) begin
      if (b == IGNORE_SET[i]) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_lookup.sv
// ---------------------------------------------------------------------------
// ps2_key_lookup
// Combinational match of an {ext, code} pair against the tracked-key table.
// Ports:
//   i_ext    in  1  E0 prefix seen for this code
//   i_code   in  8  final scancode byte
//   o_hit    out 1  pair is a tracked key
//   o_index  out 4  held-bitmap index of the matching key (0 when no hit)
// ---------------------------------------------------------------------------
module ps2_key_lookup
  import ps2_key_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output logic       o_hit,
  output logic [3:0] o_index
);

  always_comb begin
    o_hit   = 1'b0;
    o_index = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keyEntry(4'(i)) == {i_ext, i_code}) begin
        o_hit   = 1'b1;
        o_index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns the raw PS/2 set-2 byte stream into make/break events, drops
// typematic repeats, keeps a held bitmap of the movement keys and presents
// one "active key" code for the pose tracker.
//
// Build option: define KEY_EXTENDED_EN to decode E0-prefixed keys (arrows
// in held[11:8]). Without it E0 is just another ignored byte, the extended
// states do not exist, and held[11:8] / keycode_ext read 0.
//
// Parameters:
//   TIMEOUT_CYCLES  clocks a pending prefix may wait for its next byte
// Ports:
//   CLOCK_50     in  1   system clock
//   reset        in  1   asynchronous reset, active-high
//   rx_data      in  8   received byte
//   rx_valid     in  1   rx_data valid strobe
//   evt_valid    out 1   one-cycle pulse per decoded event
//   evt_code     out 8   final scancode of the last event
//   evt_ext      out 1   last event carried E0
//   evt_make     out 1   last event was a press
//   held         out 12  held bitmap of tracked keys
//   keycode      out 8   active tracked key, 0x00 if none
//   keycode_ext  out 1   E0 flag of keycode
// ---------------------------------------------------------------------------
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        evt_valid,
  output logic [7:0]  evt_code,
  output logic        evt_ext,
  output logic        evt_make,
  output logic [11:0] held,
  output logic [7:0]  keycode,
  output logic        keycode_ext
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef KEY_EXTENDED_EN
  localparam logic        EXT_EN    = 1'b1;
  localparam logic [11:0] HELD_MASK = 12'hFFF;
`else
  localparam logic        EXT_EN    = 1'b0;
  localparam logic [11:0] HELD_MASK = 12'h0FF;
`endif

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_count;
  logic             w_timeout;
  logic             w_isIgnore;
  logic             w_seqDone;
  logic             w_seqExt;
  logic             w_seqMake;
  logic             w_hit;
  logic [3:0]       w_index;
  logic [11:0]      w_idxMask;
  logic             w_keyHeld;
  logic             w_repeat;
  logic             w_fire;
  logic [11:0]      w_heldAfter;
  key_entry_t       w_lowEntry;

  logic             r_evtValid;
  logic [7:0]       r_evtCode;
  logic             r_evtExt;
  logic             r_evtMake;
  logic [11:0]      r_held;
  logic [7:0]       r_keycode;
  logic             r_keycodeExt;

  // With extended decoding off, E0 is dropped like any housekeeping byte.
  assign w_isIgnore = isIgnoreByte(rx_data) | (~EXT_EN & (rx_data == SC_EXT));
  assign w_timeout  = (r_state != ST_IDLE) && (r_count == CNT_LAST);

  // Prefix parser. A byte arriving on the expiry cycle is still decoded in
  // the current state; the timeout only applies when nothing arrives.
  always_comb begin
    w_nextState = r_state;
    w_seqDone   = 1'b0;
    w_seqExt    = 1'b0;
    w_seqMake   = 1'b0;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SC_BREAK) begin
            w_nextState = ST_BRK;
          end
`ifdef KEY_EXTENDED_EN
          else if (rx_data == SC_EXT) begin
            w_nextState = ST_EXT;
          end
`endif
          else if (!w_isIgnore) begin
            w_seqDone = 1'b1;
            w_seqMake = 1'b1;
          end
        end
        ST_BRK: begin
          w_nextState = ST_IDLE;
          w_seqDone   = !w_isIgnore && (rx_data != SC_EXT);
        end
`ifdef KEY_EXTENDED_EN
        ST_EXT: begin
          if (rx_data == SC_BREAK) begin
            w_nextState = ST_EXT_BRK;
          end else begin
            w_nextState = ST_IDLE;
            w_seqDone   = !w_isIgnore && (rx_data != SC_EXT);
            w_seqExt    = 1'b1;
            w_seqMake   = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          w_nextState = ST_IDLE;
          w_seqDone   = !w_isIgnore && (rx_data != SC_EXT) && (rx_data != SC_BREAK);
          w_seqExt    = 1'b1;
        end
`endif
        default: w_nextState = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_nextState = ST_IDLE;
    end
  end

  ps2_key_lookup u_lookup (
    .i_ext   (w_seqExt),
    .i_code  (rx_data),
    .o_hit   (w_hit),
    .o_index (w_index)
  );

  assign w_idxMask   = 12'b1 << w_index;
  assign w_keyHeld   = |(r_held & w_idxMask);
  assign w_heldAfter = r_held & ~w_idxMask;

  // A make of a key that is already down is the keyboard's auto-repeat.
  assign w_repeat = w_seqMake && w_hit && w_keyHeld;
  assign w_fire   = w_seqDone && !w_repeat;

  // Fallback active key after a release: lowest index still held.
  always_comb begin
    w_lowEntry = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_heldAfter[i]) w_lowEntry = keyEntry(4'(i));
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      if (rx_valid || (w_nextState == ST_IDLE)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_evtValid   <= 1'b0;
      r_evtCode    <= 8'h00;
      r_evtExt     <= 1'b0;
      r_evtMake    <= 1'b0;
      r_held       <= 12'h000;
      r_keycode    <= 8'h00;
      r_keycodeExt <= 1'b0;
    end else begin
      r_evtValid <= w_fire;
      if (w_fire) begin
        r_evtCode <= rx_data;
        r_evtExt  <= w_seqExt;
        r_evtMake <= w_seqMake;
      end
      if (w_fire && w_hit) begin
        if (w_seqMake) begin
          r_held       <= r_held | w_idxMask;
          r_keycode    <= rx_data;
          r_keycodeExt <= w_seqExt;
        end else if (w_keyHeld) begin
          r_held <= w_heldAfter;
          if ((r_keycode == rx_data) && (r_keycodeExt == w_seqExt)) begin
            r_keycode    <= w_lowEntry.code;
            r_keycodeExt <= w_lowEntry.ext;
          end
        end
      end
    end
  end

  assign evt_valid   = r_evtValid;
  assign evt_code    = r_evtCode;
  assign evt_ext     = r_evtExt;
  assign evt_make    = r_evtMake;
  assign held        = r_held & HELD_MASK;
  assign keycode     = r_keycode;
  assign keycode_ext = r_keycodeExt & EXT_EN;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Drives byte streams into ps2_key_decoder. A reference model keeps the
// prefix/held/active-key picture and queues every expected event; a monitor
// pops the queue on each evt_valid pulse.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int T = 16;

`ifdef KEY_EXTENDED_EN
  localparam bit EXT_ON = 1'b1;
`else
  localparam bit EXT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        evt_valid;
  logic [7:0]  evt_code;
  logic        evt_ext;
  logic        evt_make;
  logic [11:0] held;
  logic [7:0]  keycode;
  logic        keycode_ext;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_make    (evt_make),
    .held        (held),
    .keycode     (keycode),
    .keycode_ext (keycode_ext)
  );

  typedef struct {
    logic [7:0]  code;
    bit          ext;
    bit          make;
    logic [11:0] heldV;
    logic [7:0]  kc;
    bit          kcExt;
  } exp_t;

  exp_t expQ[$];

  logic [7:0] keyCodes [12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h15, 8'h24,
                                8'h2D, 8'h2B, 8'h75, 8'h72, 8'h6B, 8'h74};
  bit         keyExts  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  logic [7:0] ignList  [6]  = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  logic [11:0] mHeld;
  logic [7:0]  mKc;
  bit          mKcExt;
  bit          pendBrk;
  bit          pendExt;
  int          lastCyc;
  logic [7:0]  mEvtCode;
  bit          mEvtExt;
  bit          mEvtMake;

  int cycCnt = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cycCnt++;

  function automatic int findKey(input logic [7:0] code, input bit ext);
    int idx;
    idx = -1;
    for (int i = 0; i < 12; i++) begin
      if (keyCodes[i] == code && keyExts[i] == ext) idx = i;
    end
    return idx;
  endfunction

  function automatic void modelReset();
    mHeld = '0; mKc = '0; mKcExt = 0;
    pendBrk = 0; pendExt = 0; lastCyc = 0;
    mEvtCode = '0; mEvtExt = 0; mEvtMake = 0;
    expQ.delete();
  endfunction

  // One complete key sequence: apply the held/active-key rules and queue
  // the event unless it is an auto-repeat.
  function automatic void modelEmit(input logic [7:0] b, input bit ext, input bit make);
    int idx;
    bit found;
    exp_t e;
    idx = findKey(b, ext);
    if (make && idx >= 0 && mHeld[idx]) return;
    if (idx >= 0) begin
      if (make) begin
        mHeld[idx] = 1'b1;
        mKc = b;
        mKcExt = ext;
      end else if (mHeld[idx]) begin
        mHeld[idx] = 1'b0;
        if (mKc == b && mKcExt == ext) begin
          mKc = 8'h00;
          mKcExt = 0;
          found = 0;
          for (int i = 0; i < 12; i++) begin
            if (!found && mHeld[i]) begin
              found = 1;
              mKc = keyCodes[i];
              mKcExt = keyExts[i];
            end
          end
        end
      end
    end
    mEvtCode = b; mEvtExt = ext; mEvtMake = make;
    e.code = b; e.ext = ext; e.make = make;
    e.heldV = mHeld; e.kc = mKc; e.kcExt = mKcExt;
    expQ.push_back(e);
  endfunction

  // Byte-level rules: prefixes accumulate, a prefix older than T clocks
  // is forgotten, and the first non-prefix byte closes the sequence.
  function automatic void modelByte(input logic [7:0] b);
    bit ign;
    if ((pendBrk || pendExt) && (cycCnt - lastCyc > T)) begin
      pendBrk = 0;
      pendExt = 0;
    end
    lastCyc = cycCnt;
    ign = 0;
    foreach (ignList[i]) if (ignList[i] == b) ign = 1;
    if (!EXT_ON && b == 8'hE0) ign = 1;
    if (!pendBrk && !pendExt) begin
      if (b == 8'hF0) pendBrk = 1;
      else if (EXT_ON && b == 8'hE0) pendExt = 1;
      else if (!ign) modelEmit(b, 0, 1);
    end else if (pendExt && !pendBrk) begin
      if (b == 8'hF0) pendBrk = 1;
      else begin
        pendExt = 0;
        if (!ign && b != 8'hE0) modelEmit(b, 1, 1);
      end
    end else if (pendBrk && !pendExt) begin
      pendBrk = 0;
      if (!ign && b != 8'hE0) modelEmit(b, 0, 0);
    end else begin
      pendBrk = 0;
      pendExt = 0;
      if (!ign && b != 8'hE0 && b != 8'hF0) modelEmit(b, 1, 0);
    end
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    modelByte(b);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_held"}, 32'(held), 32'(mHeld));
    checkVal({tag, "_keycode"}, 32'(keycode), 32'(mKc));
    checkVal({tag, "_keycode_ext"}, 32'(keycode_ext), 32'(mKcExt));
    checkVal({tag, "_evt_hold"}, {23'd0, evt_valid, evt_ext, evt_make, evt_code},
             {23'd0, 1'b0, mEvtExt, mEvtMake, mEvtCode});
    checkVal({tag, "_pending_events"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    checkVal({tag, "_evt_code"}, 32'(evt_code), 32'd0);
    checkVal({tag, "_evt_ext_make"}, {30'd0, evt_ext, evt_make}, 32'd0);
    checkVal({tag, "_held"}, 32'(held), 32'd0);
    checkVal({tag, "_keycode"}, 32'(keycode), 32'd0);
    checkVal({tag, "_keycode_ext"}, 32'(keycode_ext), 32'd0);
  endtask

  // Monitor: every evt_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && evt_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_event: actual code=%0h ext=%0b make=%0b required no event",
                 evt_code, evt_ext, evt_make);
      end else begin
        e = expQ.pop_front();
        if (evt_code !== e.code || evt_ext !== e.ext || evt_make !== e.make ||
            held !== e.heldV || keycode !== e.kc || keycode_ext !== e.kcExt) begin
          failures++;
          $display("[TB] FAIL event: actual code=%0h ext=%0b make=%0b held=%0h kc=%0h kcx=%0b required code=%0h ext=%0b make=%0b held=%0h kc=%0h kcx=%0b",
                   evt_code, evt_ext, evt_make, held, keycode, keycode_ext,
                   e.code, e.ext, e.make, e.heldV, e.kc, e.kcExt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int g;
    logic [7:0] b;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_state");
    reset = 1'b0;
    idleCycles(2);

    // Single press and release of W.
    applyStimulus(8'h1D); idleCycles(2);
    checkOutput("w_make");
    checkVal("w_make_held_const", 32'(held), 32'h001);
    checkVal("w_make_kc_const", 32'(keycode), 32'h1D);
    applyStimulus(8'hF0); applyStimulus(8'h1D); idleCycles(2);
    checkOutput("w_break");
    checkVal("w_break_held_const", 32'(held), 32'h000);

    // Auto-repeat suppression, back-to-back strobes, active-key fallback.
    applyStimulus(8'h1D); applyStimulus(8'h1D); applyStimulus(8'h1D);
    applyStimulus(8'h1C); idleCycles(2);
    checkOutput("repeat");
    checkVal("repeat_held_const", 32'(held), 32'h003);
    checkVal("repeat_kc_const", 32'(keycode), 32'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C); idleCycles(2);
    checkOutput("fallback");
    checkVal("fallback_kc_const", 32'(keycode), 32'h1D);
    applyStimulus(8'hF0); applyStimulus(8'h1D); idleCycles(2);
    checkOutput("release_all");

    // Extended Up arrow.
    applyStimulus(8'hE0); applyStimulus(8'h75); idleCycles(2);
    checkOutput("up_make");
    checkVal("up_make_held_const", 32'(held), EXT_ON ? 32'h100 : 32'h000);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75); idleCycles(2);
    checkOutput("up_break");
    checkVal("up_break_held_const", 32'(held), 32'h000);

    // Prefix timeout, including both sides of the expiry boundary.
    applyStimulus(8'hF0); idleCycles(20); applyStimulus(8'h23); idleCycles(2);
    checkOutput("timeout_make");
    checkVal("timeout_make_held_const", 32'(held), 32'h008);
    applyStimulus(8'hF0); idleCycles(T - 1); applyStimulus(8'h23); idleCycles(2);
    checkOutput("gap_at_limit");
    checkVal("gap_at_limit_held_const", 32'(held), 32'h000);
    applyStimulus(8'h23); idleCycles(2);
    applyStimulus(8'hF0); idleCycles(T); applyStimulus(8'h23); idleCycles(2);
    checkOutput("gap_past_limit");
    checkVal("gap_past_limit_held_const", 32'(held), 32'h008);
    applyStimulus(8'hF0); applyStimulus(8'h23); idleCycles(2);
    checkOutput("release_d");

    // Housekeeping bytes produce nothing.
    applyStimulus(8'hAA); applyStimulus(8'hFA); applyStimulus(8'hF0);
    applyStimulus(8'hFE); applyStimulus(8'h24); idleCycles(2);
    checkOutput("ignore");
    checkVal("ignore_held_const", 32'(held), 32'h020);
    applyStimulus(8'hF0); applyStimulus(8'h24); idleCycles(2);
    checkOutput("release_e");

    // Reset in the middle of a break sequence.
    applyStimulus(8'h23); idleCycles(2);
    applyStimulus(8'hF0); idleCycles(1);
    #2 reset = 1'b1;
    #1 checkResetOutputs("mid_reset");
    modelReset();
    idleCycles(2);
    reset = 1'b0;
    idleCycles(1);
    applyStimulus(8'h23); idleCycles(2);
    checkOutput("after_reset");
    checkVal("after_reset_held_const", 32'(held), 32'h008);

    // Randomized stream against the model.
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      b = keyCodes[$urandom_range(0, 11)];
      else if (r < 45) b = 8'hF0;
      else if (r < 58) b = 8'hE0;
      else if (r < 68) b = ignList[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(0, 255));
      applyStimulus(b);
      g = $urandom_range(0, 99);
      if (g >= 85)      idleCycles($urandom_range(T - 2, T + 2));
      else if (g >= 35) idleCycles($urandom_range(1, 3));
      if (n % 25 == 24) begin
        idleCycles(2);
        checkOutput("random");
      end
    end
    idleCycles(T + 4);
    checkOutput("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
